// File: rtl/quant_array_param.sv
// Per-channel requantizer: multiply by a mode-selected scale, round-shift, saturate and
// optional ReLU, in a fixed 3-stage pipeline with four shared configuration sets.

`ifndef CONV_IN_BIT_WIDTH_F
`define CONV_IN_BIT_WIDTH_F 8
`endif

module quant_array_param #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned IN_W    = 32,
  parameter int unsigned OUT_W   = `CONV_IN_BIT_WIDTH_F,
  parameter int unsigned MULT_W  = 16,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*IN_W-1:0]  in_data,
  input  logic [NUM_CH-1:0]       quant_en,
  input  logic [1:0]              conv_compute_mode,
  input  logic                    cfg_wr_en,
  input  logic [1:0]              cfg_mode,
  input  logic [MULT_W-1:0]       cfg_mult,
  input  logic [SHIFT_W-1:0]      cfg_shift,
  input  logic                    cfg_relu,
  input  logic                    sat_clr,
  output logic [NUM_CH*OUT_W-1:0] quant_o_data,
  output logic [NUM_CH-1:0]       quant_valid,
  output logic [NUM_CH-1:0]       sat_flag
);

  localparam int unsigned ProdW = IN_W + MULT_W;
  localparam int unsigned ExtW  = ProdW + 1;

  localparam logic signed [ExtW-1:0] SatMax =
    $signed({{(ExtW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ExtW-1:0] SatMin =
    $signed({{(ExtW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});
  localparam logic [OUT_W-1:0] OutMax = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OutMin = {1'b1, {(OUT_W-1){1'b0}}};

  // Configuration sets, one per compute mode
  logic [MULT_W-1:0]  mult_q  [4];
  logic [SHIFT_W-1:0] shift_q [4];
  logic               relu_q  [4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int m = 0; m < 4; m++) begin
        mult_q[m]  <= MULT_W'(1);
        shift_q[m] <= '0;
        relu_q[m]  <= 1'b0;
      end
    end else if (cfg_wr_en) begin
      mult_q[cfg_mode]  <= cfg_mult;
      shift_q[cfg_mode] <= cfg_shift;
      relu_q[cfg_mode]  <= cfg_relu;
    end
  end

  // All channels advance in lockstep, so the selected set travels once per stage.
  // S1 reads the pre-write registers, so a same-edge write is seen only by later samples.
  logic [MULT_W-1:0]  s1_mult_q;
  logic [SHIFT_W-1:0] s1_shift_q, s2_shift_q;
  logic               s1_relu_q, s2_relu_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_mult_q  <= '0;
      s1_shift_q <= '0;
      s1_relu_q  <= 1'b0;
      s2_shift_q <= '0;
      s2_relu_q  <= 1'b0;
    end else begin
      s1_mult_q  <= mult_q[conv_compute_mode];
      s1_shift_q <= shift_q[conv_compute_mode];
      s1_relu_q  <= relu_q[conv_compute_mode];
      s2_shift_q <= s1_shift_q;
      s2_relu_q  <= s1_relu_q;
    end
  end

  // Half-LSB rounding bias for the current S3 shift amount
  logic [ExtW-1:0] rnd_bias;

  always_comb begin
    rnd_bias = '0;
    if (s2_shift_q != '0) begin
      rnd_bias = ExtW'(1) << (s2_shift_q - SHIFT_W'(1));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                    s1_valid_q, s2_valid_q, out_valid_q, sat_q;
    logic [IN_W-1:0]         s1_data_q;
    logic signed [ProdW-1:0] prod;
    logic [ProdW-1:0]        s2_prod_q;
    logic signed [ExtW-1:0]  ext, rnd, shifted;
    logic [OUT_W-1:0]        sat_val, res, out_q;
    logic                    clip;

    // Both operands sign-extended to the product width so the low ProdW bits are exact
    assign prod = $signed({{MULT_W{s1_data_q[IN_W-1]}}, s1_data_q}) *
                  $signed({{IN_W{s1_mult_q[MULT_W-1]}}, s1_mult_q});

    always_comb begin
      ext     = $signed({s2_prod_q[ProdW-1], s2_prod_q});
      rnd     = ext + $signed(rnd_bias);
      shifted = rnd >>> s2_shift_q;
      clip    = 1'b0;
      sat_val = shifted[OUT_W-1:0];
      if (shifted > SatMax) begin
        clip    = 1'b1;
        sat_val = OutMax;
      end else if (shifted < SatMin) begin
        clip    = 1'b1;
        sat_val = OutMin;
      end
      res = sat_val;
      if (s2_relu_q && sat_val[OUT_W-1]) begin
        res = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_valid_q  <= 1'b0;
        s1_data_q   <= '0;
        s2_valid_q  <= 1'b0;
        s2_prod_q   <= '0;
        out_valid_q <= 1'b0;
        out_q       <= '0;
        sat_q       <= 1'b0;
      end else begin
        s1_valid_q <= quant_en[i];
        if (quant_en[i]) begin
          s1_data_q <= in_data[i*IN_W +: IN_W];
        end
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_prod_q <= prod;
        end
        out_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          out_q <= res;
        end
        // A clip on the same edge as a clear keeps the flag set
        if (s2_valid_q && clip) begin
          sat_q <= 1'b1;
        end else if (sat_clr) begin
          sat_q <= 1'b0;
        end
      end
    end

    assign quant_o_data[i*OUT_W +: OUT_W] = out_q;
    assign quant_valid[i]                 = out_valid_q;
    assign sat_flag[i]                    = sat_q;
  end

endmodule

// File: tb/tb_quant_array_param.sv
// Scoreboard bench for quant_array_param: directed samples push expected results,
// an independent negedge monitor pops and checks value, arrival cycle and sat_flag.

module tb_quant_array_param;

  localparam int NUM_CH = 4;
  localparam int IN_W   = 32;
  localparam int OUT_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH*IN_W-1:0]  in_data;
  logic [NUM_CH-1:0]       quant_en;
  logic [1:0]              conv_compute_mode;
  logic                    cfg_wr_en;
  logic [1:0]              cfg_mode;
  logic [15:0]             cfg_mult;
  logic [4:0]              cfg_shift;
  logic                    cfg_relu;
  logic                    sat_clr;
  logic [NUM_CH*OUT_W-1:0] quant_o_data;
  logic [NUM_CH-1:0]       quant_valid;
  logic [NUM_CH-1:0]       sat_flag;

  quant_array_param #(
    .NUM_CH (NUM_CH),
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .MULT_W (16),
    .SHIFT_W(5)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_data          (in_data),
    .quant_en         (quant_en),
    .conv_compute_mode(conv_compute_mode),
    .cfg_wr_en        (cfg_wr_en),
    .cfg_mode         (cfg_mode),
    .cfg_mult         (cfg_mult),
    .cfg_shift        (cfg_shift),
    .cfg_relu         (cfg_relu),
    .sat_clr          (sat_clr),
    .quant_o_data     (quant_o_data),
    .quant_valid      (quant_valid),
    .sat_flag         (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [7:0] data;
    int         due;
    int         sat;   // -1: do not check
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int ch, input int val, input int sat);
    exp_t e;
    e.ch   = ch;
    e.data = 8'(val);
    e.due  = cyc + 3;
    e.sat  = sat;
    sb.push_back(e);
  endtask

  task automatic drive(input int ch, input int val);
    in_data[ch*IN_W +: IN_W] = 32'(val);
    quant_en[ch] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    quant_en = '0;
    repeat (n) tick();
  endtask

  task automatic cfg(input int mode, input int mult, input int shift, input bit relu);
    cfg_wr_en = 1'b1;
    cfg_mode  = 2'(mode);
    cfg_mult  = 16'(mult);
    cfg_shift = 5'(shift);
    cfg_relu  = relu;
  endtask

  // Monitor
  always @(negedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      int idx;
      idx = -1;
      for (int k = 0; k < sb.size(); k++) begin
        if (idx < 0 && sb[k].ch == ch) idx = k;
      end
      if (quant_valid[ch] === 1'b1) begin
        if (idx < 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_valid ch%0d: got valid with data %0h, required none (cycle %0d)",
                   ch, quant_o_data[ch*OUT_W +: OUT_W], cyc);
        end else begin
          chk($sformatf("data_ch%0d", ch), 64'(quant_o_data[ch*OUT_W +: OUT_W]),
              64'(sb[idx].data));
          chk($sformatf("latency_ch%0d", ch), 64'(cyc), 64'(sb[idx].due));
          if (sb[idx].sat >= 0) begin
            chk($sformatf("sat_ch%0d", ch), 64'(sat_flag[ch]), 64'(sb[idx].sat));
          end
          sb.delete(idx);
        end
      end else if (idx >= 0 && sb[idx].due <= cyc) begin
        compared++;
        mismatched++;
        $display("FAIL missing_valid ch%0d: got no valid, required data %0h at cycle %0d",
                 ch, sb[idx].data, sb[idx].due);
        sb.delete(idx);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_data = '0;
    quant_en = '0;
    conv_compute_mode = 2'd0;
    cfg_wr_en = 1'b0;
    cfg_mode = 2'd0;
    cfg_mult = '0;
    cfg_shift = '0;
    cfg_relu = 1'b0;
    sat_clr = 1'b0;
    repeat (3) tick();
    chk("reset_valid", 64'(quant_valid), 64'h0);
    chk("reset_data", 64'(quant_o_data), 64'h0);
    chk("reset_sat", 64'(sat_flag), 64'h0);

    // Identity after reset, first sample on the first released edge
    rst_n = 1'b1;
    conv_compute_mode = 2'd0;
    drive(0, 5);    push(0, 5, 0);
    drive(1, -7);   push(1, -7, 0);
    drive(2, 200);  push(2, 127, 1);
    drive(3, -300); push(3, -128, 1);
    tick();
    idle(4);
    chk("identity_sat", 64'(sat_flag), 64'hC);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_clear", 64'(sat_flag), 64'h0);

    // Rounding, mode1: x*3 + 2 >> 2
    cfg(1, 3, 2, 1'b0);
    tick();
    cfg_wr_en = 1'b0;
    conv_compute_mode = 2'd1;
    drive(0, 5);  push(0, 4, 0);  tick();
    drive(0, -5); push(0, -4, 0); tick();
    drive(0, 6);  push(0, 5, 0);  tick();
    idle(4);

    // ReLU, mode2
    cfg(2, 1, 0, 1'b1);
    tick();
    cfg_wr_en = 1'b0;
    conv_compute_mode = 2'd2;
    drive(0, -50);   push(0, 0, 0); tick();
    drive(0, -1000); push(0, 0, 1); tick();
    idle(4);

    // Saturation event on the same edge as sat_clr keeps the flag
    conv_compute_mode = 2'd0;
    drive(2, 1000); push(2, 127, 1);
    tick();
    idle(1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_clear_after_collision", 64'(sat_flag), 64'h0);

    // Config hazard: same-edge write uses old set
    cfg(0, 2, 0, 1'b0);
    conv_compute_mode = 2'd0;
    drive(0, 10); push(0, 10, -1);
    tick();
    cfg_wr_en = 1'b0;
    drive(0, 10); push(0, 20, -1);
    tick();
    idle(4);

    // Sparse enable on mode3 (identity)
    conv_compute_mode = 2'd3;
    drive(0, 1); push(0, 1, 0);
    in_data[1*IN_W +: IN_W] = 32'd2;
    drive(2, 3); push(2, 3, 0);
    in_data[3*IN_W +: IN_W] = 32'd4;
    tick();
    idle(4);
    chk("sparse_hold_ch1", 64'(quant_o_data[1*OUT_W +: OUT_W]), 64'hF9);
    chk("sparse_hold_ch3", 64'(quant_o_data[3*OUT_W +: OUT_W]), 64'h80);

    // Reset mid-stream: in-flight samples must vanish, config returns to identity
    conv_compute_mode = 2'd0;
    for (int c = 0; c < NUM_CH; c++) drive(c, 1);
    tick();
    tick();
    quant_en = '0;
    rst_n = 1'b0;
    tick();
    chk("midreset_valid", 64'(quant_valid), 64'h0);
    chk("midreset_data", 64'(quant_o_data), 64'h0);
    chk("midreset_sat", 64'(sat_flag), 64'h0);
    rst_n = 1'b1;
    conv_compute_mode = 2'd0;
    drive(0, 9); push(0, 9, 0); tick();
    quant_en = '0;
    conv_compute_mode = 2'd1;
    drive(1, 7); push(1, 7, 0); tick();
    quant_en = '0;
    conv_compute_mode = 2'd2;
    drive(2, -5); push(2, -5, 0); tick();
    idle(6);

    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
